// File: rtl/io_strobe_seq_pkg.sv
// Shared definitions for the I/O strobe sequencer: state encoding and
// default bus-cycle timing.
package io_strobe_seq_pkg;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int DEF_SETUP = 1;
  localparam int DEF_PW    = 2;
  localparam int DEF_HOLD  = 1;
  localparam int DEF_TMO   = 15;
endpackage

// File: rtl/io_strobe_seq_cyc_cnt.sv
// 8-bit loadable cycle counter with clear; tc flags that the current
// cycle is the last one of a run of `term` cycles (cnt+1 == term).
module cyc_cnt (
  input  logic       cp,
  input  logic       rst_,
  input  logic       clr,
  input  logic       ld,
  input  logic [7:0] ld_val,
  input  logic       en,
  input  logic [7:0] term,
  output logic [7:0] cnt,
  output logic       tc
);
  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = 8'd0;
    else if (ld) cnt_d = ld_val;
    else if (en) cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge cp) begin
    if (!rst_) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = ({1'b0, cnt_q} + 9'd1) == {1'b0, term};
endmodule

// File: rtl/io_strobe_seq.sv
// Bus-cycle sequencer: turns a one-cycle host request into a timed
// select/enable/strobe cycle for the 8-way decoder, with ack timeout.
module io_strobe_seq
  import io_strobe_seq_pkg::*;
#(
  parameter int SETUP = DEF_SETUP,
  parameter int PW    = DEF_PW,
  parameter int HOLD  = DEF_HOLD,
  parameter int TMO   = DEF_TMO
) (
  input  logic       cp,
  input  logic       rst_,
  input  logic       req,
  input  logic       we,
  input  logic [2:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       c,
  output logic       b,
  output logic       a,
  output logic       e1_,
  output logic       e2_,
  output logic       e3,
  output logic       e4,
  output logic       rd_,
  output logic       wr_,
  input  logic       ack_,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       doe
);
  localparam logic [8:0] PW_C  = 9'(PW);
  localparam logic [8:0] TMO_C = 9'(TMO);

  logic [1:0] state_d, state_q;
  logic       we_d, we_q;
  logic [2:0] addr_d, addr_q;
  logic [7:0] dout_d, dout_q;
  logic [7:0] rdata_d, rdata_q;
  logic       busy_d, busy_q, done_d, done_q, err_d, err_q;
  logic       en_d, en_q;   // enables asserted (e1_/e2_ low, e3/e4 high)
  logic       rd_d, rd_q, wr_d, wr_q, doe_d, doe_q;

  logic       cnt_clr, cnt_en, cnt_tc;
  logic [7:0] cnt, cnt_term;
  logic [8:0] n1;

  // SETUP and HOLD share the terminal compare; STROBE needs two thresholds
  assign cnt_term = (state_q == S_SETUP) ? 8'(SETUP) : 8'(HOLD);
  assign n1       = {1'b0, cnt} + 9'd1;

  cyc_cnt u_cnt (
    .cp     (cp),
    .rst_   (rst_),
    .clr    (cnt_clr),
    .ld     (1'b0),
    .ld_val (8'd0),
    .en     (cnt_en),
    .term   (cnt_term),
    .cnt    (cnt),
    .tc     (cnt_tc)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    en_d    = en_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    doe_d   = doe_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          dout_d  = wdata;
          busy_d  = 1'b1;
          en_d    = 1'b1;
          err_d   = 1'b0;
          doe_d   = we;
          cnt_clr = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_tc) begin
          rd_d    = we_q;
          wr_d    = ~we_q;
          cnt_clr = 1'b1;
          state_d = S_STROBE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      S_STROBE: begin
        // ack wins over timeout when both land on the same edge
        if (n1 >= PW_C && !ack_) begin
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          if (!we_q) rdata_d = din;
          cnt_clr = 1'b1;
          state_d = S_HOLD;
        end else if (n1 == TMO_C) begin
          rd_d    = 1'b1;
          wr_d    = 1'b1;
          err_d   = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        if (cnt_tc) begin
          en_d    = 1'b0;
          doe_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_clr = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_en = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge cp) begin
    if (!rst_) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 3'd0;
      dout_q  <= 8'd0;
      rdata_q <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
      rd_q    <= 1'b1;
      wr_q    <= 1'b1;
      doe_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      en_q    <= en_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      doe_q   <= doe_d;
    end
  end

  assign {c, b, a} = addr_q;
  assign e1_   = ~en_q;
  assign e2_   = ~en_q;
  assign e3    = en_q;
  assign e4    = en_q;
  assign rd_   = rd_q;
  assign wr_   = wr_q;
  assign dout  = dout_q;
  assign doe   = doe_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign err   = err_q;
endmodule

// File: tb/tb_io_strobe_seq.sv
// Randomized bench for io_strobe_seq against a transaction-level model of
// strobe width, busy length, error and read-data behaviour.
module tb_io_strobe_seq;
  localparam int S = 1, PW = 2, H = 1, TMO = 15;

  logic       cp = 1'b0, rst_ = 1'b0, req = 1'b0, we = 1'b0, ack_ = 1'b1;
  logic [2:0] addr = 3'd0;
  logic [7:0] wdata = 8'd0, din = 8'd0;
  logic [7:0] rdata, dout;
  logic       busy, done, err, c, b, a, e1_, e2_, e3, e4, rd_, wr_, doe;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_rdata = 8'd0;

  always #5 cp = ~cp;

  io_strobe_seq #(.SETUP(S), .PW(PW), .HOLD(H), .TMO(TMO)) dut (
    .cp(cp), .rst_(rst_), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .err(err), .c(c), .b(b), .a(a),
    .e1_(e1_), .e2_(e2_), .e3(e3), .e4(e4), .rd_(rd_), .wr_(wr_),
    .ack_(ack_), .din(din), .dout(dout), .doe(doe)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_strobes"}, {rd_, wr_}, 2'b11);
    chk({tag, "_en"}, {e1_, e2_, e3, e4}, 4'b1100);
    chk({tag, "_bdo"}, {busy, done, doe}, 3'b000);
  endtask

  // Drive a request at the current (negative) edge.
  task automatic start(input logic w, input logic [2:0] ad, input logic [7:0] wd);
    req = 1'b1; we = w; addr = ad; wdata = wd;
  endtask

  // Follow one accepted cycle to its done pulse. The decoder is modelled by
  // holding ack_ high for the first D strobe-low cycles, then low.
  task automatic measure(input logic w, input logic [2:0] ad, input logic [7:0] wd,
                         input logic [7:0] din_v, input int D, input bit keep);
    int busy_n, str_n, str_start, exp_w;
    bit seen_done, exp_err;
    exp_err = (D >= TMO);
    exp_w   = exp_err ? TMO : ((D + 1 > PW) ? D + 1 : PW);
    busy_n = 0; str_n = 0; str_start = -1; seen_done = 0;
    din = din_v;
    for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
      @(negedge cp);
      if (!keep) req = 1'b0;
      chk("strobe_excl", {rd_, wr_} == 2'b00, 1'b0);
      if (done) seen_done = 1;
      else if (busy) begin
        if (busy_n == 0) chk("err_cleared", err, 1'b0);
        chk("sel", {c, b, a}, ad);
        chk("en_active", {e1_, e2_, e3, e4}, 4'b0011);
        chk("doe", doe, w);
        if (w) chk("dout", dout, wd);
        if (!rd_ || !wr_) begin
          if (str_start < 0) str_start = busy_n;
          chk("strobe_kind", rd_, w);
          ack_ = (str_n < D) ? 1'b1 : 1'b0;
          str_n++;
        end else ack_ = 1'b1;
        busy_n++;
      end
    end
    ack_ = 1'b1;
    chk("done_seen", seen_done, 1'b1);
    chk("busy_len", busy_n, S + exp_w + H);
    chk("strobe_len", str_n, exp_w);
    chk("strobe_start", str_start, S);
    chk("err", err, exp_err);
    if (!w && !exp_err) exp_rdata = din_v;
    chk("rdata", rdata, exp_rdata);
    chk("done_busy", busy, 1'b0);
    chk("done_en", {e1_, e2_, e3, e4, doe}, 5'b11000);
    if (!keep) begin
      @(negedge cp);
      chk("done_pulse", done, 1'b0);
    end
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge cp);
    chk_idle_outputs("rst");
    chk("rst_err", err, 1'b0);
    chk("rst_rdata", rdata, 8'd0);
    chk("rst_sel", {c, b, a, dout}, 11'd0);
    rst_ = 1'b1;
    @(negedge cp);

    // Write, immediate ack
    start(1'b1, 3'd5, 8'hA5);
    measure(1'b1, 3'd5, 8'hA5, 8'h00, 0, 0);
    // Read, ack delayed 4 strobe cycles
    start(1'b0, 3'd3, 8'h00);
    measure(1'b0, 3'd3, 8'h00, 8'h3C, 4, 0);
    // Timeout read keeps old rdata, next request clears err
    start(1'b0, 3'd7, 8'h00);
    measure(1'b0, 3'd7, 8'h00, 8'hEE, 1000, 0);
    start(1'b1, 3'd1, 8'h5A);
    measure(1'b1, 3'd1, 8'h5A, 8'h00, 0, 0);
    // Ack on exactly the timeout edge is a success
    start(1'b0, 3'd2, 8'h00);
    measure(1'b0, 3'd2, 8'h00, 8'h77, TMO - 1, 0);

    // req held high: second cycle starts on the done-cycle edge
    start(1'b0, 3'd6, 8'h11);
    measure(1'b0, 3'd6, 8'h11, 8'h42, 1, 1);
    measure(1'b0, 3'd6, 8'h11, 8'h99, 2, 0);

    // Reset in the middle of a strobe
    start(1'b0, 3'd4, 8'h00);
    repeat (S + 3) @(negedge cp);
    req = 1'b0;
    chk("mid_strobe_low", rd_, 1'b0);
    rst_ = 1'b0;
    @(negedge cp);
    rst_ = 1'b1;
    chk_idle_outputs("abort");
    chk("abort_err", err, 1'b0);
    chk("abort_rdata", rdata, 8'd0);
    exp_rdata = 8'd0;
    dn = 0;
    repeat (30) begin
      @(negedge cp);
      if (done || busy) dn++;
    end
    chk("abort_no_done", dn, 0);

    // Random traffic
    for (int i = 0; i < 40; i++) begin
      logic w;
      logic [2:0] ad;
      logic [7:0] wd, dv;
      int d;
      w  = 1'($urandom_range(0, 1));
      ad = 3'($urandom_range(0, 7));
      wd = 8'($urandom_range(0, 255));
      dv = 8'($urandom_range(0, 255));
      d  = (i % 8 == 7) ? 200 : int'($urandom_range(0, TMO + 3));
      start(w, ad, wd);
      measure(w, ad, wd, dv, d, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
